sfft_sequencer: RTL and testbench

- Run controller for the stochastic FFT array (uButterfly network); sequences one transform per start request.
- Captures the twiddle configuration and drives the datapath's clear, weight-load and enable controls.
- Counts ones on every real/imag output bitstream over a fixed 2^BITWIDTH-cycle window, converting unary results back to binary counts.
- Sits between the system control/config interface and the SFFT datapath.

---
 rtl/sfft_sequencer_if.sv | 32 +++
 rtl/sfft_sequencer.sv | 145 ++++++++++++++
 tb/tb_sfft_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfft_sequencer_if.sv
// Bundle of control, config, datapath-stream and result signals between the
// system side and the SFFT run controller. The slave modport is the sequencer.
interface sfft_sequencer_if #(
  parameter int BITWIDTH  = 8,
  parameter int NUMINPUTS = 2
);
  logic                              iStart;
  logic                              iAbort;
  logic [BITWIDTH-1:0]               iwRealCfg;
  logic [BITWIDTH-1:0]               iwImgCfg;
  logic [NUMINPUTS-1:0]              iReal;
  logic [NUMINPUTS-1:0]              iImg;
  logic                              oClr;
  logic                              oLoadW;
  logic                              oEn;
  logic [BITWIDTH-1:0]               owReal;
  logic [BITWIDTH-1:0]               owImg;
  logic                              oBusy;
  logic                              oDone;
  logic [NUMINPUTS*(BITWIDTH+1)-1:0] oCntReal;
  logic [NUMINPUTS*(BITWIDTH+1)-1:0] oCntImg;

  modport master (
    output iStart, iAbort, iwRealCfg, iwImgCfg, iReal, iImg,
    input  oClr, oLoadW, oEn, owReal, owImg, oBusy, oDone, oCntReal, oCntImg
  );

  modport slave (
    input  iStart, iAbort, iwRealCfg, iwImgCfg, iReal, iImg,
    output oClr, oLoadW, oEn, owReal, owImg, oBusy, oDone, oCntReal, oCntImg
  );
endinterface

// File: rtl/sfft_sequencer.sv
// Run controller for the stochastic FFT datapath: one transform per start,
// IDLE -> CLEAR -> LOAD -> RUN (L+PIPE_LAT cycles) -> DONE, counting ones on
// every real/imag output stream over the last L RUN cycles.
// Optional macro SFFT_SEQ_CONT_EN: iStart in DONE loops straight to CLEAR.
module sfft_sequencer #(
  parameter int BITWIDTH  = 8,
  parameter int NUMINPUTS = 2,
  parameter int PIPE_LAT  = 1
) (
  input  logic             iClk,
  input  logic             iRstN,
  sfft_sequencer_if.slave  bus
);

  localparam int CNTW    = BITWIDTH + 1;
  localparam int RUN_LEN = (1 << BITWIDTH) + PIPE_LAT;
  localparam int CW      = $clog2(RUN_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cyc_q, cyc_d;
  logic [NUMINPUTS-1:0][CNTW-1:0]  acc_r_q, acc_r_d;
  logic [NUMINPUTS-1:0][CNTW-1:0]  acc_i_q, acc_i_d;
  logic [NUMINPUTS-1:0][CNTW-1:0]  cnt_r_q, cnt_r_d;
  logic [NUMINPUTS-1:0][CNTW-1:0]  cnt_i_q, cnt_i_d;
  logic [BITWIDTH-1:0]             wr_q, wr_d;
  logic [BITWIDTH-1:0]             wi_q, wi_d;
  logic                            capture;

  // State, counters, accumulators, result and twiddle registers
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      acc_r_q <= '0;
      acc_i_q <= '0;
      cnt_r_q <= '0;
      cnt_i_q <= '0;
      wr_q    <= '0;
      wi_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
      cnt_r_q <= cnt_r_d;
      cnt_i_q <= cnt_i_d;
      wr_q    <= wr_d;
      wi_q    <= wi_d;
    end
  end

  // Next-state, accumulation and result capture
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    cnt_r_d = cnt_r_q;
    cnt_i_d = cnt_i_q;
    wr_d    = wr_q;
    wi_d    = wi_q;
    capture = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.iStart && !bus.iAbort) begin
          state_d = ST_CLEAR;
          capture = 1'b1;
        end
      end
      ST_CLEAR: begin
        acc_r_d = '0;
        acc_i_d = '0;
        cyc_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cyc_q >= CW'(PIPE_LAT)) begin
          for (int unsigned k = 0; k < NUMINPUTS; k++) begin
            acc_r_d[k] = acc_r_q[k] + CNTW'(bus.iReal[k]);
            acc_i_d[k] = acc_i_q[k] + CNTW'(bus.iImg[k]);
          end
        end
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CW'(RUN_LEN - 1)) begin
          // The final RUN bit is folded in here so results line up with oDone.
          cnt_r_d = acc_r_d;
          cnt_i_d = acc_i_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef SFFT_SEQ_CONT_EN
        if (bus.iStart) begin
          state_d = ST_CLEAR;
          capture = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything: drop back to IDLE and keep old results.
    if (bus.iAbort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_r_d = cnt_r_q;
      cnt_i_d = cnt_i_q;
      capture = 1'b0;
    end

    if (capture) begin
      wr_d = bus.iwRealCfg;
      wi_d = bus.iwImgCfg;
    end
  end

  // Control outputs decoded from the registered state
  always_comb begin
    bus.oClr     = (state_q == ST_CLEAR);
    bus.oLoadW   = (state_q == ST_LOAD);
    bus.oEn      = (state_q == ST_RUN);
    bus.oDone    = (state_q == ST_DONE);
    bus.oBusy    = (state_q != ST_IDLE);
    bus.owReal   = wr_q;
    bus.owImg    = wi_q;
    bus.oCntReal = cnt_r_q;
    bus.oCntImg  = cnt_i_q;
  end

endmodule

// File: tb/tb_sfft_sequencer.sv
// Self-checking bench for sfft_sequencer (BITWIDTH=4, NUMINPUTS=4, PIPE_LAT=2).
module tb_sfft_sequencer;

  localparam int BW      = 4;
  localparam int NI      = 4;
  localparam int PL      = 2;
  localparam int L       = 1 << BW;
  localparam int RUN_LEN = L + PL;
  localparam int DONE_T  = 3 + L + PL;
  localparam int CW      = BW + 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sfft_sequencer_if #(.BITWIDTH(BW), .NUMINPUTS(NI)) bus ();

  sfft_sequencer #(.BITWIDTH(BW), .NUMINPUTS(NI), .PIPE_LAT(PL)) dut (
    .iClk  (clk),
    .iRstN (rstn),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [NI-1:0]    stim_r [RUN_LEN];
  logic [NI-1:0]    stim_i [RUN_LEN];
  logic [NI*CW-1:0] prev_r, prev_i;

  typedef struct {
    logic [BW-1:0]    cr;
    logic [BW-1:0]    ci;
    logic [NI-1:0]    rfill;
    logic [NI-1:0]    ifill;
    logic [NI*CW-1:0] exp_r;
    logic [NI*CW-1:0] exp_i;
  } vec_t;

  vec_t vt [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: per lane, number of ones seen in RUN cycles past the pipeline latency.
  function automatic logic [NI*CW-1:0] model_counts(input bit imag);
    logic [NI*CW-1:0] r;
    int unsigned ones;
    r = '0;
    for (int k = 0; k < NI; k++) begin
      ones = 0;
      for (int c = PL; c < RUN_LEN; c++) ones += imag ? stim_i[c][k] : stim_r[c][k];
      r[k*CW +: CW] = CW'(ones);
    end
    return r;
  endfunction

  task automatic fill_const(input logic [NI-1:0] rf, input logic [NI-1:0] imf);
    for (int c = 0; c < RUN_LEN; c++) begin
      stim_r[c] = rf;
      stim_i[c] = imf;
    end
  endtask

  task automatic fill_random();
    for (int c = 0; c < RUN_LEN; c++) begin
      stim_r[c] = NI'($urandom);
      stim_i[c] = NI'($urandom);
    end
  endtask

  // Control outputs expected at cycle t after the accepted start edge.
  task automatic check_ctrl(input int t, input string tag);
    check($sformatf("%s clr t=%0d", tag, t),  bus.oClr,   (t == 1));
    check($sformatf("%s load t=%0d", tag, t), bus.oLoadW, (t == 2));
    check($sformatf("%s en t=%0d", tag, t),   bus.oEn,    (t >= 3 && t < DONE_T));
    check($sformatf("%s done t=%0d", tag, t), bus.oDone,  (t == DONE_T));
    check($sformatf("%s busy t=%0d", tag, t), bus.oBusy,  (t >= 1 && t <= DONE_T));
  endtask

  task automatic drive_cycle(input int t);
    if (t >= 3 && t < DONE_T) begin
      bus.iReal = stim_r[t-3];
      bus.iImg  = stim_i[t-3];
    end else begin
      bus.iReal = NI'($urandom);
      bus.iImg  = NI'($urandom);
    end
  endtask

  task automatic start(input logic [BW-1:0] cr, input logic [BW-1:0] ci);
    bus.iwRealCfg = cr;
    bus.iwImgCfg  = ci;
    bus.iStart    = 1'b1;
    bus.iAbort    = 1'b0;
    step();
    bus.iStart    = 1'b0;
    bus.iwRealCfg = BW'($urandom);
    bus.iwImgCfg  = BW'($urandom);
  endtask

  // Full transform with timeline, twiddle-hold and count checks; restart_c
  // re-pulses iStart at that RUN cycle index (-1 for none).
  task automatic run(input logic [BW-1:0] cr, input logic [BW-1:0] ci,
                     input int restart_c, input string tag);
    logic [NI*CW-1:0] exp_r, exp_i;
    exp_r = model_counts(1'b0);
    exp_i = model_counts(1'b1);
    start(cr, ci);
    for (int t = 1; t <= DONE_T; t++) begin
      drive_cycle(t);
      bus.iStart = (t - 3 == restart_c);
      check_ctrl(t, tag);
      check($sformatf("%s owReal t=%0d", tag, t), bus.owReal, cr);
      check($sformatf("%s owImg t=%0d", tag, t),  bus.owImg,  ci);
      if (t < DONE_T) begin
        check($sformatf("%s cntR hold t=%0d", tag, t), bus.oCntReal, prev_r);
        check($sformatf("%s cntI hold t=%0d", tag, t), bus.oCntImg,  prev_i);
      end else begin
        check($sformatf("%s cntR", tag), bus.oCntReal, exp_r);
        check($sformatf("%s cntI", tag), bus.oCntImg,  exp_i);
      end
      step();
    end
    bus.iStart = 1'b0;
    check($sformatf("%s busy after", tag), bus.oBusy, 1'b0);
    check($sformatf("%s done after", tag), bus.oDone, 1'b0);
    check($sformatf("%s cntR after", tag), bus.oCntReal, exp_r);
    check($sformatf("%s owReal after", tag), bus.owReal, cr);
    prev_r = exp_r;
    prev_i = exp_i;
  endtask

  initial begin
    logic [NI*CW-1:0] cnt_now;
    logic [BW-1:0]    c_r, c_i;
    int               p;

    vt[0] = '{4'h5, 4'hA, 4'b1111, 4'b0000, {4{5'd16}}, '0};
    vt[1] = '{4'h3, 4'hC, 4'b1010, 4'b0101, {5'd16, 5'd0, 5'd16, 5'd0}, {5'd0, 5'd16, 5'd0, 5'd16}};
    vt[2] = '{4'hF, 4'h0, 4'b0000, 4'b1111, '0, {4{5'd16}}};
    vt[3] = '{4'h0, 4'hF, 4'b0001, 4'b1000, {5'd0, 5'd0, 5'd0, 5'd16}, {5'd16, 5'd0, 5'd0, 5'd0}};

    rstn          = 1'b0;
    bus.iStart    = 1'b0;
    bus.iAbort    = 1'b0;
    bus.iwRealCfg = '0;
    bus.iwImgCfg  = '0;
    bus.iReal     = '0;
    bus.iImg      = '0;
    prev_r        = '0;
    prev_i        = '0;
    step();
    step();

    // Reset values
    check("rst busy", bus.oBusy, 1'b0);
    check("rst done", bus.oDone, 1'b0);
    check("rst en",   bus.oEn,   1'b0);
    check("rst clr",  bus.oClr,  1'b0);
    check("rst load", bus.oLoadW, 1'b0);
    check("rst cntR", bus.oCntReal, '0);
    check("rst cntI", bus.oCntImg,  '0);
    check("rst owR",  bus.owReal, '0);
    check("rst owI",  bus.owImg,  '0);
    rstn = 1'b1;
    step();

    // Directed table: constant per-lane streams held through the whole run
    for (int v = 0; v < 4; v++) begin
      fill_const(vt[v].rfill, vt[v].ifill);
      run(vt[v].cr, vt[v].ci, -1, $sformatf("vec%0d", v));
      check($sformatf("vec%0d tableR", v), bus.oCntReal, vt[v].exp_r);
      check($sformatf("vec%0d tableI", v), bus.oCntImg,  vt[v].exp_i);
    end

    // Lane 0 high only during the latency cycles: must not be counted
    fill_const('0, '0);
    stim_r[0][0] = 1'b1;
    stim_r[1][0] = 1'b1;
    run(4'h5, 4'hA, -1, "latency");
    cnt_now = bus.oCntReal;
    check("latency lane0", cnt_now[0 +: CW], '0);

    // Start re-pulsed mid-RUN is ignored
    fill_random();
    run(4'h6, 4'h9, 4, "restart");

    // Abort at RUN c=7
    fill_random();
    start(4'h7, 4'h8);
    for (int t = 1; t <= 10; t++) begin
      drive_cycle(t);
      check_ctrl(t, "abort");
      if (t == 10) bus.iAbort = 1'b1;
      step();
    end
    bus.iAbort = 1'b0;
    check("abort en",   bus.oEn,    1'b0);
    check("abort busy", bus.oBusy,  1'b0);
    check("abort clr",  bus.oClr,   1'b0);
    check("abort load", bus.oLoadW, 1'b0);
    for (int t = 0; t < DONE_T; t++) begin
      check($sformatf("abort nodone %0d", t), bus.oDone, 1'b0);
      step();
    end
    check("abort cntR", bus.oCntReal, prev_r);
    check("abort cntI", bus.oCntImg,  prev_i);

    // Normal run after abort
    fill_random();
    run(4'h2, 4'hD, -1, "postabort");

    // Reset at RUN c=5
    fill_random();
    start(4'hB, 4'h4);
    for (int t = 1; t <= 8; t++) begin
      drive_cycle(t);
      check_ctrl(t, "midrst");
      if (t == 8) rstn = 1'b0;
      step();
    end
    check("midrst busy", bus.oBusy, 1'b0);
    check("midrst en",   bus.oEn,   1'b0);
    check("midrst done", bus.oDone, 1'b0);
    check("midrst cntR", bus.oCntReal, '0);
    check("midrst cntI", bus.oCntImg,  '0);
    check("midrst owR",  bus.owReal, '0);
    check("midrst owI",  bus.owImg,  '0);
    rstn   = 1'b1;
    prev_r = '0;
    prev_i = '0;
    step();
    check("midrst stays idle", bus.oBusy, 1'b0);

    // Start and abort together in IDLE, abort alone in IDLE
    bus.iStart = 1'b1;
    bus.iAbort = 1'b1;
    step();
    check("idle start+abort busy", bus.oBusy, 1'b0);
    bus.iStart = 1'b0;
    step();
    check("idle abort busy", bus.oBusy, 1'b0);
    bus.iAbort = 1'b0;

    // Randomized runs against the reference model
    for (int r = 0; r < 4; r++) begin
      fill_random();
      c_r = BW'($urandom);
      c_i = BW'($urandom);
      run(c_r, c_i, -1, $sformatf("rand%0d", r));
    end

    // iStart held high: back-to-back transforms
    bus.iwRealCfg = 4'h1;
    bus.iwImgCfg  = 4'h2;
    bus.iStart    = 1'b1;
    step();
    for (int t = 1; t <= 66; t++) begin
      bus.iReal = NI'($urandom);
      bus.iImg  = NI'($urandom);
`ifdef SFFT_SEQ_CONT_EN
      p = (t - 1) % (DONE_T);
      check($sformatf("loop busy t=%0d", t), bus.oBusy, 1'b1);
`else
      p = (t - 1) % (DONE_T + 1);
      check($sformatf("loop busy t=%0d", t), bus.oBusy, (p != DONE_T));
`endif
      check($sformatf("loop done t=%0d", t), bus.oDone, (p == DONE_T - 1));
      check($sformatf("loop clr t=%0d", t),  bus.oClr,  (p == 0));
      step();
    end
    bus.iStart = 1'b0;
    for (int t = 0; t < DONE_T + 2; t++) step();
    check("loop final idle", bus.oBusy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
